// File: rtl/rv_task3_pkg.sv
// Shared constants and types for the task-3 RV64I-subset processor.
package rv_task3_pkg;

  localparam int XLEN       = 64;
  localparam int IMEM_BYTES = 128;
  localparam int DMEM_WORDS = 64;
  localparam int N_ELEM     = 7;

  // Major opcodes
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LD_SD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4
  } alu_op_e;

  // Contents loaded into data memory whenever reset asserts.
  function automatic logic [XLEN-1:0] init_word(input int idx);
    case (idx)
      0:       return 64'd7;
      1:       return 64'd3;
      2:       return 64'd9;
      3:       return 64'd1;
      4:       return 64'd5;
      5:       return 64'd2;
      6:       return 64'd8;
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv64_alu.sv
// 64-bit combinational ALU with zero and signed less-than flags.
module rv64_alu
  import rv_task3_pkg::*;
(
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            lt_o
);

  // Operation select; arithmetic wraps modulo 2^64, shifts use the low six bits.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLL: result_o = a_i << b_i[5:0];
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign lt_o   = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/risc_v_processor_task3.sv
// Single-cycle RV64I-subset core running a built-in bubble sort over seven
// doublewords; the array is exported continuously on element1..element7.
module risc_v_processor_task3
  import rv_task3_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] element1,
  output logic [XLEN-1:0] element2,
  output logic [XLEN-1:0] element3,
  output logic [XLEN-1:0] element4,
  output logic [XLEN-1:0] element5,
  output logic [XLEN-1:0] element6,
  output logic [XLEN-1:0] element7
);

  localparam int IMEM_AW = $clog2(IMEM_BYTES);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  // Program ROM: nested bubble sort (x2 = n-1, x1 outer, x3 inner, x4 pointer),
  // swap stores the smaller value first, then parks on beq x0,x0,0.
  function automatic logic [31:0] rom_word(input logic [IMEM_AW-3:0] idx);
    case (idx)
      5'd0:    return 32'h00600113; // addi x2,x0,6
      5'd1:    return 32'h00000093; // addi x1,x0,0
      5'd2:    return 32'h00000193; // outer: addi x3,x0,0
      5'd3:    return 32'h00000213; // addi x4,x0,0
      5'd4:    return 32'h00023283; // inner: ld x5,0(x4)
      5'd5:    return 32'h00823303; // ld x6,8(x4)
      5'd6:    return 32'h00534463; // blt x6,x5,swap
      5'd7:    return 32'h00000663; // beq x0,x0,next
      5'd8:    return 32'h00623023; // swap: sd x6,0(x4)
      5'd9:    return 32'h00523423; // sd x5,8(x4)
      5'd10:   return 32'h00820213; // next: addi x4,x4,8
      5'd11:   return 32'h00118193; // addi x3,x3,1
      5'd12:   return 32'hfe2190e3; // bne x3,x2,inner
      5'd13:   return 32'h00108093; // addi x1,x1,1
      5'd14:   return 32'hfc2098e3; // bne x1,x2,outer
      5'd15:   return 32'h00000063; // halt: beq x0,x0,0
      default: return 32'h00000000;
    endcase
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] dmem_q [DMEM_WORDS];

  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_result, wb_val;
  logic            alu_zero, alu_lt;
  alu_op_e         alu_op;
  logic            rf_we, mem_we, wb_from_mem, branch_taken;
  logic [DMEM_AW-1:0] dmem_addr;

  // Fetch: anything past the ROM reads as 0, which decodes as a NOP.
  assign instr = (pc_q < XLEN'(IMEM_BYTES)) ? rom_word(pc_q[IMEM_AW-1:2]) : 32'h0;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  // Main decode: unrecognised encodings leave every enable low (NOP).
  always_comb begin
    alu_op      = ALU_ADD;
    alu_b       = rs2_val;
    rf_we       = 1'b0;
    mem_we      = 1'b0;
    wb_from_mem = 1'b0;
    case (opcode)
      OP: begin
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: begin alu_op = ALU_ADD; rf_we = 1'b1; end
          {F7_SUB,  F3_ADD_SUB}: begin alu_op = ALU_SUB; rf_we = 1'b1; end
          {F7_BASE, F3_AND}:     begin alu_op = ALU_AND; rf_we = 1'b1; end
          {F7_BASE, F3_OR}:      begin alu_op = ALU_OR;  rf_we = 1'b1; end
          default: ;
        endcase
      end
      OP_IMM: begin
        alu_b = imm_i;
        if (funct3 == F3_ADD_SUB) begin
          alu_op = ALU_ADD;
          rf_we  = 1'b1;
        end else if (funct3 == F3_SLL && funct7[6:1] == 6'b0) begin
          alu_op = ALU_SLL;
          rf_we  = 1'b1;
        end
      end
      LOAD: begin
        if (funct3 == F3_LD_SD) begin
          alu_b       = imm_i;
          rf_we       = 1'b1;
          wb_from_mem = 1'b1;
        end
      end
      STORE: begin
        if (funct3 == F3_LD_SD) begin
          alu_b  = imm_s;
          mem_we = 1'b1;
        end
      end
      BRANCH: alu_op = ALU_SUB;
      default: ;
    endcase
  end

  // Branch resolution from the ALU flags of rs1 - rs2.
  always_comb begin
    branch_taken = 1'b0;
    if (opcode == BRANCH) begin
      case (funct3)
        F3_BEQ:  branch_taken = alu_zero;
        F3_BNE:  branch_taken = ~alu_zero;
        F3_BLT:  branch_taken = alu_lt;
        default: branch_taken = 1'b0;
      endcase
    end
  end

  rv64_alu u_alu (
    .op_i     (alu_op),
    .a_i      (rs1_val),
    .b_i      (alu_b),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .lt_o     (alu_lt)
  );

  assign dmem_addr = alu_result[DMEM_AW+2:3];
  assign wb_val    = wb_from_mem ? dmem_q[dmem_addr] : alu_result;
  assign pc_d      = branch_taken ? (pc_q + imm_b) : (pc_q + XLEN'(4));

  // Architectural state commit; reset restores PC, registers and the initial array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= init_word(i);
    end else begin
      pc_q <= pc_d;
      if (rf_we && rd != 5'd0) regs_q[rd] <= wb_val;
      if (mem_we) dmem_q[dmem_addr] <= rs2_val;
    end
  end

  assign element1 = dmem_q[0];
  assign element2 = dmem_q[1];
  assign element3 = dmem_q[2];
  assign element4 = dmem_q[3];
  assign element5 = dmem_q[4];
  assign element6 = dmem_q[5];
  assign element7 = dmem_q[6];

endmodule

// File: tb/tb_risc_v_processor_task3.sv
// Scoreboard bench: a bubble-sort model queues every expected array state,
// a negedge monitor pops and compares whenever the exported array changes.
module tb_risc_v_processor_task3;
  import rv_task3_pkg::*;

  typedef logic [6:0][63:0] arr_t;

  logic        clk;
  logic        reset;
  logic [63:0] element1, element2, element3, element4, element5, element6, element7;

  int   tests_run = 0;
  int   failed    = 0;
  arr_t exp_q[$];

  alu_op_e     alu_op;
  logic [63:0] alu_a, alu_b, alu_res;
  logic        alu_zero, alu_lt;

  risc_v_processor_task3 dut (
    .clk      (clk),
    .reset    (reset),
    .element1 (element1),
    .element2 (element2),
    .element3 (element3),
    .element4 (element4),
    .element5 (element5),
    .element6 (element6),
    .element7 (element7)
  );

  rv64_alu u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .lt_o     (alu_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic arr_t init_arr();
    arr_t a;
    a[0] = 64'd7; a[1] = 64'd3; a[2] = 64'd9; a[3] = 64'd1;
    a[4] = 64'd5; a[5] = 64'd2; a[6] = 64'd8;
    return a;
  endfunction

  function automatic arr_t sorted_arr();
    arr_t a;
    a[0] = 64'd1; a[1] = 64'd2; a[2] = 64'd3; a[3] = 64'd5;
    a[4] = 64'd7; a[5] = 64'd8; a[6] = 64'd9;
    return a;
  endfunction

  function automatic arr_t sample();
    arr_t s;
    s[0] = element1; s[1] = element2; s[2] = element3; s[3] = element4;
    s[4] = element5; s[5] = element6; s[6] = element7;
    return s;
  endfunction

  // A swap in progress: exactly one slot has already taken its final value.
  function automatic bit is_half(arr_t c, arr_t l, arr_t e);
    int n = 0;
    bit ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (c[i] !== l[i]) begin
        n++;
        if (c[i] !== e[i] || e[i] === l[i]) ok = 1'b0;
      end
    end
    return ok && (n == 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_arr(input string tag, input arr_t req);
    arr_t cur;
    cur = sample();
    for (int i = 0; i < 7; i++)
      check($sformatf("%s_element%0d", tag, i + 1), cur[i], req[i]);
  endtask

  // Reference: textbook bubble sort; every swap yields one queued array state.
  task automatic build_model();
    arr_t a;
    logic [63:0] t;
    a = init_arr();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6 - i; j++) begin
        if ($signed(a[j]) > $signed(a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          exp_q.push_back(a);
        end
      end
    end
  endtask

  // Monitor: compares the exported array against the scoreboard on every change.
  initial begin : monitor
    arr_t cur, last, half_snap;
    bit half;
    last = init_arr();
    half = 1'b0;
    half_snap = '0;
    forever begin
      @(negedge clk);
      cur = sample();
      if (reset) begin
        last = init_arr();
        half = 1'b0;
        tests_run++;
        if (cur !== init_arr()) begin
          failed++;
          $display("FAIL in_reset_array: actual=%h required=%h", cur, init_arr());
        end
      end else if (cur !== last) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_change: actual=%h required=%h", cur, last);
          last = cur;
          half = 1'b0;
        end else if (cur === exp_q[0]) begin
          last = cur;
          half = 1'b0;
          void'(exp_q.pop_front());
          $display("[TB] swap committed (%0d left): %h", exp_q.size(), cur);
        end else if (!half && is_half(cur, last, exp_q[0])) begin
          half = 1'b1;
          half_snap = cur;
        end else begin
          failed++;
          $display("FAIL swap_step: actual=%h required=%h", cur, exp_q[0]);
          last = cur;
          half = 1'b0;
        end
      end
    end
  end

  // Holds reset, releases it, then lets the program run to its halt loop.
  task automatic run_and_check(input int hold_cycles, input string tag);
    logic [63:0] pc0;
    build_model();
    repeat (hold_cycles) @(posedge clk);
    #2;
    check_arr({tag, "_held"}, init_arr());
    reset = 1'b0;
    #1;
    check_arr({tag, "_released"}, init_arr());
    repeat (1000) @(posedge clk);
    #1;
    check({tag, "_swaps_pending"}, 64'(exp_q.size()), 64'd0);
    check_arr({tag, "_final"}, sorted_arr());
    pc0 = dut.pc_q;
    repeat (100) @(posedge clk);
    #1;
    check_arr({tag, "_stable"}, sorted_arr());
    check({tag, "_pc_halt"}, dut.pc_q, pc0);
    $display("[TB] run %s done, pc=%0h array=%h", tag, dut.pc_q, sample());
  endtask

  // Starts a run and asserts reset asynchronously partway through it.
  task automatic restart_and_abort(input int cyc, input int off);
    build_model();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (cyc) @(posedge clk);
    #off reset = 1'b1;
    #1;
    check_arr($sformatf("abort_c%0d", cyc), init_arr());
    $display("[TB] reset asserted after %0d cycles (+%0d ns)", cyc, off);
  endtask

  task automatic alu_one(input alu_op_e op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    alu_op = op; alu_a = a; alu_b = b;
    #1;
    case (op)
      ALU_ADD: exp = a + b;
      ALU_SUB: exp = a - b;
      ALU_AND: exp = a & b;
      ALU_OR:  exp = a | b;
      default: exp = a << b[5:0];
    endcase
    check($sformatf("alu_%s_result", op.name()), alu_res, exp);
    check("alu_lt", {63'b0, alu_lt}, {63'b0, ($signed(a) < $signed(b))});
    check("alu_zero", {63'b0, alu_zero}, {63'b0, (exp == 64'd0)});
    $display("[TB] alu %s a=%h b=%h -> %h", op.name(), a, b, alu_res);
  endtask

  initial begin : stimulus
    int cyc, off;
    logic [63:0] ra, rb;
    reset  = 1'b0;
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    #1 reset = 1'b1;
    #1 check_arr("reset_assert", init_arr());
    run_and_check(3, "power_on");

    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_arr("reset_after_halt", init_arr());

    restart_and_abort(50, 3);
    run_and_check(2, "restart_c50");

    for (int k = 0; k < 3; k++) begin
      cyc = int'($urandom_range(5, 300));
      off = int'($urandom_range(1, 8));
      if (off == 5) off = 6;
      restart_and_abort(cyc, off);
      run_and_check(int'($urandom_range(1, 3)), $sformatf("restart_rand%0d", k));
    end

    // Directed ALU corner cases: wraparound, signed compare, equality.
    alu_one(ALU_SUB, 64'd0, 64'd1);
    check("sub_wrap", alu_res, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_one(ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("blt_neg1_vs_1", {63'b0, alu_lt}, 64'd1);
    alu_one(ALU_SUB, 64'h1234, 64'h1234);
    check("bne_equal_not_taken", {63'b0, alu_zero}, 64'd1);

    for (int k = 0; k < 30; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 5 == 4) rb = ra;
      alu_one(alu_op_e'($urandom_range(0, 4)), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
